// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
// The BUS_* command codes normally come from sys_defs.vh. The fallback
// definitions below are used only when that header has not been read first,
// and they carry the same values.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} arb_state_t;
  // Width of the DM-streak counter. It supports MAX_DM_STREAK values up to 15.
  localparam int STREAK_W = 4;
endpackage

// File: rtl/mem_arb_streak_ctr.sv
// Saturating counter of consecutive DM grants made while IF was waiting.
// Compiled only when MEM_ARB_STARVE_EN is defined. The default build has no
// counter logic.
`ifdef MEM_ARB_STARVE_EN
module mem_arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);
  logic [STREAK_W-1:0] cnt;

  // Clear has priority over increment. The count sticks at MAX and never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 cnt <= '0;
    else if (clr)                            cnt <= '0;
    else if (inc && (cnt != STREAK_W'(MAX))) cnt <= cnt + 1'b1;
  end

  assign at_max = (cnt == STREAK_W'(MAX));
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetches and MEM loads/stores.
// One transaction is in flight at a time. Outputs to memory and the acks are
// registered. By default DM wins every tie.
// Optional macro MEM_ARB_STARVE_EN: after MAX_DM_STREAK DM grants in a row
// while IF was waiting, IF wins the next tie.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_data,
  input  logic [1:0]    dm_cmd,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_din,
  output logic          dm_ack,
  output logic [DW-1:0] dm_dout,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic          mem_rdy,
  input  logic [DW-1:0] mem_dout,
  output logic          if_stall,
  output logic          dm_stall
);
  arb_state_t state, state_nxt;
  logic dm_pend, grant_dm, grant_if, done, starve_if;

  assign dm_pend  = (dm_cmd != `BUS_NONE);
  assign grant_dm = (state == IDLE) && dm_pend && !(if_req && starve_if);
  assign grant_if = (state == IDLE) && if_req && !grant_dm;
  assign done     = ((state == BUSY_IF) || (state == BUSY_DM)) && mem_rdy;

`ifdef MEM_ARB_STARVE_EN
  logic streak_clr, streak_inc;
  assign streak_clr = (state == IDLE) && (!if_req || grant_if);
  assign streak_inc = grant_dm && if_req;
  mem_arb_streak_ctr #(.MAX(MAX_DM_STREAK)) u_streak (
    .clk    (clk),
    .rst    (rst),
    .clr    (streak_clr),
    .inc    (streak_inc),
    .at_max (starve_if)
  );
`else
  assign starve_if = 1'b0;
`endif

  // State register. An async reset aborts any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state. Grants are made only from IDLE, and RESP always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_dm) state_nxt = BUSY_DM;
               else if (grant_if) state_nxt = BUSY_IF;
      BUSY_IF,
      BUSY_DM: if (mem_rdy) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory command launch and response capture. The acks are one-cycle pulses
  // that are high exactly while in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cmd  <= `BUS_NONE;
      mem_addr <= '0;
      mem_din  <= '0;
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      if_data  <= '0;
      dm_dout  <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (grant_dm) begin
        mem_cmd  <= dm_cmd;
        mem_addr <= dm_addr;
        mem_din  <= dm_din;
      end else if (grant_if) begin
        mem_cmd  <= `BUS_LOAD;
        mem_addr <= if_addr;
        mem_din  <= '0;
      end else if (done) begin
        mem_cmd <= `BUS_NONE;
        if (state == BUSY_IF) begin
          if_ack  <= 1'b1;
          if_data <= mem_dout;
        end else begin
          dm_ack <= 1'b1;
          if (mem_cmd == `BUS_LOAD) dm_dout <= mem_dout;
        end
      end
    end
  end

  assign if_stall = if_req && !if_ack;
  assign dm_stall = dm_pend && !dm_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester tasks push expected
// responses, a negedge monitor pops and compares on each ack and checks the
// grant/hold/response protocol against a simple model of the arbitration rules.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

module tb_mem_port_arbiter;
  localparam int MAXS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_data;
  logic [1:0]  dm_cmd = `BUS_NONE;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_din = '0;
  logic        dm_ack;
  logic [31:0] dm_dout;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_rdy = 1'b0;
  logic [31:0] mem_dout = '0;
  logic        if_stall, dm_stall;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_DM_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .dm_cmd(dm_cmd), .dm_addr(dm_addr), .dm_din(dm_din), .dm_ack(dm_ack), .dm_dout(dm_dout),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_rdy(mem_rdy), .mem_dout(mem_dout),
    .if_stall(if_stall), .dm_stall(dm_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Initial memory image. Address 0x100 holds a known instruction.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // ---------------- memory environment ----------------
  logic [31:0] mem [logic [31:0]];
  int busy_cnt = 0;
  int wait_k   = 0;
  int force_k  = -1;   // -1 means the wait is random (0..3 cycles)

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : imem(a);
  endfunction

  always @(posedge clk) begin
    #1;
    if (mem_cmd != `BUS_NONE) begin
      if (busy_cnt == 0) wait_k = (force_k >= 0) ? force_k : int'($urandom_range(0, 3));
      mem_rdy = (busy_cnt == wait_k);
      busy_cnt++;
      mem_dout = (mem_rdy && mem_cmd == `BUS_LOAD) ? mem_rd(mem_addr) : $urandom;
      if (mem_rdy && mem_cmd == `BUS_STORE) mem[mem_addr] = mem_din;
    end else begin
      busy_cnt = 0;
      mem_rdy  = 1'($urandom_range(0, 1));  // noise that the DUT must ignore
      mem_dout = $urandom;
    end
  end

  // ---------------- reference model / scoreboard queues ----------------
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] ref_dm [logic [31:0]];
  logic [31:0] last_load = '0;

  task automatic if_txn(input logic [31:0] a, output int lat);
    if_req = 1'b1; if_addr = a;
    if_q.push_back(imem(a));
    lat = -1;
    do begin @(negedge clk); lat++; end while (!if_ack && lat < 60);
    if (!if_ack) begin
      checks++; fails++;
      $display("FAIL if_ack_timeout: no ack for addr %h", a);
      if_q.delete();
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dm_txn(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d, output int lat);
    dm_cmd = c; dm_addr = a; dm_din = d;
    if (c == `BUS_STORE) begin
      ref_dm[a] = d;
      dm_q.push_back(last_load);
    end else begin
      last_load = ref_dm.exists(a) ? ref_dm[a] : imem(a);
      dm_q.push_back(last_load);
    end
    lat = -1;
    do begin @(negedge clk); lat++; end while (!dm_ack && lat < 60);
    if (!dm_ack) begin
      checks++; fails++;
      $display("FAIL dm_ack_timeout: no ack for addr %h", a);
      dm_q.delete();
    end
    @(posedge clk); #1;
    dm_cmd = `BUS_NONE;
  endtask

  // ---------------- monitor ----------------
  logic [1:0]  p_cmd = `BUS_NONE, p_dmcmd = `BUS_NONE;
  logic [31:0] p_addr, p_din, p_ifaddr, p_dmaddr, p_dmdin;
  logic        p_ifreq = 1'b0, p_rdy = 1'b0, p_ack = 1'b0;
  logic        owner_if = 1'b0;
  int          streak = 0;

  always @(negedge clk) begin : mon
    logic dm_win;
    if (rst) begin
      streak = 0;
    end else begin
      chk("if_stall", 32'(if_stall), 32'(if_req && !if_ack));
      chk("dm_stall", 32'(dm_stall), 32'((dm_cmd != `BUS_NONE) && !dm_ack));
      chk("ack_excl", 32'(if_ack && dm_ack), 32'(0));
      if (if_ack) begin
        if (if_q.size() == 0) begin checks++; fails++; $display("FAIL if_ack_spurious: got 1 expected 0"); end
        else chk("if_data", if_data, if_q.pop_front());
      end
      if (dm_ack) begin
        if (dm_q.size() == 0) begin checks++; fails++; $display("FAIL dm_ack_spurious: got 1 expected 0"); end
        else chk("dm_dout", dm_dout, dm_q.pop_front());
      end
      if (p_ack) begin
        chk("resp_no_grant", 32'(mem_cmd), 32'(`BUS_NONE));
        chk("resp_ack_once", 32'({if_ack, dm_ack}), 32'(0));
      end else if (p_cmd == `BUS_NONE) begin
        dm_win = (p_dmcmd != `BUS_NONE);
`ifdef MEM_ARB_STARVE_EN
        if (p_ifreq && streak == MAXS) dm_win = 1'b0;
        if (!p_ifreq)    streak = 0;
        else if (dm_win) streak = (streak < MAXS) ? streak + 1 : MAXS;
        else             streak = 0;
`endif
        chk("idle_no_ack", 32'({if_ack, dm_ack}), 32'(0));
        if (dm_win) begin
          owner_if = 1'b0;
          chk("grant_dm_cmd", 32'(mem_cmd), 32'(p_dmcmd));
          chk("grant_dm_addr", mem_addr, p_dmaddr);
          if (p_dmcmd == `BUS_STORE) chk("grant_dm_din", mem_din, p_dmdin);
        end else if (p_ifreq) begin
          owner_if = 1'b1;
          chk("grant_if_cmd", 32'(mem_cmd), 32'(`BUS_LOAD));
          chk("grant_if_addr", mem_addr, p_ifaddr);
        end else begin
          chk("idle_stay", 32'(mem_cmd), 32'(`BUS_NONE));
        end
      end else if (p_rdy) begin
        chk("done_cmd", 32'(mem_cmd), 32'(`BUS_NONE));
        chk("done_ack", 32'({if_ack, dm_ack}), owner_if ? 32'(2) : 32'(1));
      end else begin
        chk("hold_cmd", 32'(mem_cmd), 32'(p_cmd));
        chk("hold_addr", mem_addr, p_addr);
        chk("hold_din", mem_din, p_din);
        chk("busy_no_ack", 32'({if_ack, dm_ack}), 32'(0));
      end
    end
    p_cmd = mem_cmd; p_addr = mem_addr; p_din = mem_din;
    p_ack = if_ack || dm_ack; p_rdy = mem_rdy;
    p_ifreq = if_req; p_ifaddr = if_addr;
    p_dmcmd = dm_cmd; p_dmaddr = dm_addr; p_dmdin = dm_din;
  end

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_mem_cmd", 32'(mem_cmd), 32'(`BUS_NONE));
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    chk("rst_acks", 32'({if_ack, dm_ack}), 32'(0));
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_dm_dout", dm_dout, 32'h0);
    #2 rst = 1'b0;

    // Reset in the middle of a DM load: the load is aborted and never acked.
    @(posedge clk); #1;
    force_k = 1;
    dm_cmd = `BUS_LOAD; dm_addr = 32'h800;
    lat = 0;
    while (mem_cmd == `BUS_NONE && lat < 10) begin @(negedge clk); lat++; end
    chk("t1_granted", 32'(mem_cmd), 32'(`BUS_LOAD));
    #2 rst = 1'b1; dm_cmd = `BUS_NONE;
    #1;
    chk("t1_rst_cmd", 32'(mem_cmd), 32'(`BUS_NONE));
    chk("t1_rst_addr", mem_addr, 32'h0);
    chk("t1_rst_ack", 32'(dm_ack), 32'(0));
    @(negedge clk); #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t1_no_ack", 32'(dm_ack), 32'(0));
      chk("t1_idle_cmd", 32'(mem_cmd), 32'(`BUS_NONE));
    end

    // Fetch with memory ready at once: ack two cycles after the request.
    @(posedge clk); #1;
    force_k = 0;
    if_txn(32'h100, lat);
    chk("t2_latency", 32'(lat), 32'(2));

    // Store with three wait cycles: ack five cycles after the request; dm_dout unchanged.
    force_k = 3;
    dm_txn(`BUS_STORE, 32'h40, 32'hDEADBEEF, lat);
    chk("t3_latency", 32'(lat), 32'(5));
    force_k = -1;
    dm_txn(`BUS_LOAD, 32'h40, 32'h0, lat);

    // IF and DM requests that arrive in the same cycle.
    fork
      if_txn(32'h404, lat);
      begin int l2; dm_txn(`BUS_LOAD, 32'h804, 32'h0, l2); end
    join

    // Random contention, including back-to-back DM traffic while IF waits.
    fork
      begin
        int l;
        for (int i = 0; i < 30; i++) begin
          int g = int'($urandom_range(0, 2));
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          if_txn(32'h400 + {22'h0, 8'($urandom_range(0, 255)), 2'b00}, l);
        end
      end
      begin
        int l;
        for (int j = 0; j < 40; j++) begin
          int g = int'($urandom_range(0, 3));
          logic [1:0] c = ($urandom_range(0, 2) == 0) ? `BUS_STORE : `BUS_LOAD;
          if (g > 2) begin repeat (g) @(posedge clk); #1; end
          dm_txn(c, 32'h800 + {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, l);
        end
      end
    join

    repeat (5) @(negedge clk);
    chk("if_q_drained", 32'(if_q.size()), 32'(0));
    chk("dm_q_drained", 32'(dm_q.size()), 32'(0));
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
